encoder_fault_monitor: RTL and testbench



---
 rtl/encoder_fault_pkg.sv | 14 +
 rtl/encoder_fault_monitor_sat_counter.sv | 39 +++
 rtl/encoder_fault_monitor.sv | 159 +++++++++++++++
 tb/tb_encoder_fault_monitor.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/encoder_fault_pkg.sv
// Shared types and widths for the encoder fault monitor.
package encoder_fault_pkg;

  localparam int CODE_W = 2;
  localparam int THR_W  = 8;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/encoder_fault_monitor_sat_counter.sv
// Saturating up-counter with a registered "at all-ones" flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;
  logic         sat_r;

  // Count register; the flag is set on the same edge the count lands on all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
      sat_r   <= 1'b0;
    end else if (clr) begin
      count_r <= {W{1'b0}};
      sat_r   <= 1'b0;
    end else if (inc && (count_r != MAX_VAL)) begin
      count_r <= count_r + ONE_VAL;
      sat_r   <= ((count_r + ONE_VAL) == MAX_VAL);
    end else begin
      count_r <= count_r;
      sat_r   <= sat_r;
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/encoder_fault_monitor.sv
// Sanitises the encoder code stream, debounces faults into a sticky alarm
// with qualified recovery, and keeps a saturating fault tally.
module encoder_fault_monitor
  import encoder_fault_pkg::*;
#(
  parameter int FAULT_THRESH = 3,
  parameter int CLEAR_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] enc_y,
  input  logic              enc_fault,
  input  logic              clr_alarm,
  output logic              out_valid,
  output logic [CODE_W-1:0] y_out,
  output logic              alarm,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fault_count,
  output logic              fault_count_sat
);

  localparam logic [THR_W-1:0] FT = THR_W'(FAULT_THRESH);
  localparam logic [THR_W-1:0] CT = THR_W'(CLEAR_THRESH);

  logic              fault_v_s;
  logic              clean_v_s;
  state_t            state_r;
  state_t            state_s;
  logic [THR_W-1:0]  consec_r;
  logic [THR_W-1:0]  consec_s;
  logic [THR_W-1:0]  clean_r;
  logic [THR_W-1:0]  clean_s;
  logic              alarm_r;
  logic              out_valid_r;
  logic [CODE_W-1:0] y_out_r;
  logic [CODE_W-1:0] last_good_r;

  assign fault_v_s = in_valid & enc_fault;
  assign clean_v_s = in_valid & ~enc_fault;

  // Next-state logic; consec/clean clamp at their thresholds by construction.
  always_comb begin
    state_s  = state_r;
    consec_s = consec_r;
    clean_s  = clean_r;
    case (state_r)
      ST_OK: begin
        if (fault_v_s) begin
          consec_s = 8'd1;
          state_s  = (FT == 8'd1) ? ST_ALARM : ST_SUSPECT;
        end else begin
          state_s = ST_OK;
        end
      end
      ST_SUSPECT: begin
        if (fault_v_s) begin
          consec_s = consec_r + 8'd1;
          if ((consec_r + 8'd1) >= FT) begin
            consec_s = FT;
            state_s  = ST_ALARM;
          end else begin
            state_s = ST_SUSPECT;
          end
        end else if (clean_v_s) begin
          consec_s = 8'd0;
          state_s  = ST_OK;
        end else begin
          state_s = ST_SUSPECT;
        end
      end
      ST_ALARM: begin
        if (fault_v_s) begin
          clean_s = 8'd0;
        end else if (clean_v_s) begin
          if ((clean_r + 8'd1) >= CT) begin
            clean_s = CT;
            state_s = ST_RECOVER;
          end else begin
            clean_s = clean_r + 8'd1;
          end
        end else begin
          state_s = ST_ALARM;
        end
      end
      ST_RECOVER: begin
        // A faulty sample outranks a same-cycle acknowledge.
        if (fault_v_s) begin
          clean_s = 8'd0;
          state_s = ST_ALARM;
        end else if (clr_alarm) begin
          consec_s = 8'd0;
          clean_s  = 8'd0;
          state_s  = ST_OK;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      default: begin
        state_s  = ST_OK;
        consec_s = 8'd0;
        clean_s  = 8'd0;
      end
    endcase
  end

  // FSM state, debounce counters and registered alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_OK;
      consec_r <= 8'd0;
      clean_r  <= 8'd0;
      alarm_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      consec_r <= consec_s;
      clean_r  <= clean_s;
      alarm_r  <= (state_s == ST_ALARM) || (state_s == ST_RECOVER);
    end
  end

  // Sanitised code path: faulty samples replay the last good code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      y_out_r     <= 2'd0;
      last_good_r <= 2'd0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        if (enc_fault) begin
          y_out_r <= last_good_r;
        end else begin
          y_out_r     <= enc_y;
          last_good_r <= enc_y;
        end
      end else begin
        y_out_r     <= y_out_r;
        last_good_r <= last_good_r;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_fault_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fault_v_s),
    .clr   (1'b0),
    .count (fault_count),
    .sat   (fault_count_sat)
  );

  assign out_valid = out_valid_r;
  assign y_out     = y_out_r;
  assign alarm     = alarm_r;
  assign state     = state_r;

endmodule

// File: tb/tb_encoder_fault_monitor.sv
// Directed bench: default-parameter instance plus a FAULT_THRESH=1, CNT_W=4 instance.
module tb_encoder_fault_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] enc_y = 2'd0;
  logic       enc_fault = 1'b0;
  logic       clr_alarm = 1'b0;

  logic       out_valid, alarm, fault_count_sat;
  logic [1:0] y_out, state;
  logic [7:0] fault_count;

  logic       out_valid2, alarm2, fault_count_sat2;
  logic [1:0] y_out2, state2;
  logic [3:0] fault_count2;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] OK = 2'd0, SUS = 2'd1, ALM = 2'd2, REC = 2'd3;

  encoder_fault_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .enc_y(enc_y),
    .enc_fault(enc_fault), .clr_alarm(clr_alarm), .out_valid(out_valid),
    .y_out(y_out), .alarm(alarm), .state(state), .fault_count(fault_count),
    .fault_count_sat(fault_count_sat)
  );

  encoder_fault_monitor #(.FAULT_THRESH(1), .CLEAR_THRESH(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .enc_y(enc_y),
    .enc_fault(enc_fault), .clr_alarm(clr_alarm), .out_valid(out_valid2),
    .y_out(y_out2), .alarm(alarm2), .state(state2), .fault_count(fault_count2),
    .fault_count_sat(fault_count_sat2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] y, input logic f, input logic c);
    in_valid = v; enc_y = y; enc_fault = f; clr_alarm = c;
    @(posedge clk); #1;
  endtask

  task automatic chk_main(input string tag, input logic ov, input logic [1:0] yo,
                          input logic [1:0] st, input logic al, input logic [7:0] fc);
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    check({tag, ".y_out"}, {6'd0, y_out}, {6'd0, yo});
    check({tag, ".state"}, {6'd0, state}, {6'd0, st});
    check({tag, ".alarm"}, {7'd0, alarm}, {7'd0, al});
    check({tag, ".fault_count"}, fault_count, fc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; enc_fault = 1'b0; clr_alarm = 1'b0; enc_y = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset state
    #2;
    chk_main("por", 1'b0, 2'd0, OK, 1'b0, 8'd0);
    check("por.sat", {7'd0, fault_count_sat}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean stream 0..3, then an idle gap
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 1'b0, 1'b0);
      chk_main($sformatf("clean%0d", i), 1'b1, 2'(i), OK, 1'b0, 8'd0);
    end
    step(1'b0, 2'd1, 1'b0, 1'b0);
    chk_main("gap", 1'b0, 2'd3, OK, 1'b0, 8'd0);

    // Two faults only reach SUSPECT, clean sample returns to OK
    step(1'b1, 2'd3, 1'b0, 1'b0); chk_main("t3a", 1'b1, 2'd3, OK,  1'b0, 8'd0);
    step(1'b1, 2'd1, 1'b1, 1'b0); chk_main("t3b", 1'b1, 2'd3, SUS, 1'b0, 8'd1);
    step(1'b1, 2'd1, 1'b1, 1'b0); chk_main("t3c", 1'b1, 2'd3, SUS, 1'b0, 8'd2);
    step(1'b1, 2'd2, 1'b0, 1'b0); chk_main("t3d", 1'b1, 2'd2, OK,  1'b0, 8'd2);

    // Three faults raise the alarm
    step(1'b1, 2'd0, 1'b1, 1'b0); chk_main("t4f1", 1'b1, 2'd2, SUS, 1'b0, 8'd3);
    step(1'b1, 2'd0, 1'b1, 1'b0); chk_main("t4f2", 1'b1, 2'd2, SUS, 1'b0, 8'd4);
    step(1'b1, 2'd0, 1'b1, 1'b0); chk_main("t4f3", 1'b1, 2'd2, ALM, 1'b1, 8'd5);
    step(1'b0, 2'd0, 1'b0, 1'b1); chk_main("t4clr_ign", 1'b0, 2'd2, ALM, 1'b1, 8'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 1'b0, 1'b0);
      chk_main($sformatf("t4c%0d", i), 1'b1, 2'd1, ALM, 1'b1, 8'd5);
    end
    step(1'b1, 2'd3, 1'b1, 1'b0); chk_main("t4f4", 1'b1, 2'd1, ALM, 1'b1, 8'd6);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, 1'b0, 1'b0);
      chk_main($sformatf("t4r%0d", i), 1'b1, 2'd2, ALM, 1'b1, 8'd6);
    end
    step(1'b1, 2'd2, 1'b0, 1'b0); chk_main("t4rec", 1'b1, 2'd2, REC, 1'b1, 8'd6);
    step(1'b0, 2'd0, 1'b0, 1'b1); chk_main("t4ack", 1'b0, 2'd2, OK, 1'b0, 8'd6);

    // Fault beats acknowledge in RECOVER
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b1, 1'b0);
    chk_main("t5alm", 1'b1, 2'd2, ALM, 1'b1, 8'd9);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
    chk_main("t5rec", 1'b1, 2'd1, REC, 1'b1, 8'd9);
    step(1'b1, 2'd3, 1'b1, 1'b1); chk_main("t5race", 1'b1, 2'd1, ALM, 1'b1, 8'd10);

    // Asynchronous reset while in ALARM with fault_count=5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 1'b1, 1'b0);
    chk_main("pre_rst", 1'b1, 2'd0, ALM, 1'b1, 8'd5);
    rst_n = 1'b0;
    #2;
    chk_main("async_rst", 1'b0, 2'd0, OK, 1'b0, 8'd0);
    check("async_rst.sat", {7'd0, fault_count_sat}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FAULT_THRESH=1 and 4-bit saturation on the second instance
    step(1'b1, 2'd1, 1'b1, 1'b0);
    check("t6.state", {6'd0, state2}, {6'd0, ALM});
    check("t6.alarm", {7'd0, alarm2}, 8'd1);
    check("t6.count1", {4'd0, fault_count2}, 8'd1);
    for (int i = 2; i <= 20; i++) begin
      step(1'b1, 2'd1, 1'b1, 1'b0);
      check($sformatf("t6.count%0d", i), {4'd0, fault_count2}, (i >= 15) ? 8'd15 : 8'(i));
      check($sformatf("t6.sat%0d", i), {7'd0, fault_count_sat2}, (i >= 15) ? 8'd1 : 8'd0);
    end
    check("t6.dflt_count", fault_count, 8'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
